// File: rtl/main_memory_if.sv
`default_nettype none
// ============================================================================
//  Module   : main_memory_if
//  Purpose  : Memory-side bus between the write-through cache (master) and
//             the main_memory backing store (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface main_memory_if #(
  parameter int NBITS = 8,
  parameter int NA    = 6
);
  logic [NA-1:0]    memAddress;
  logic [NBITS-1:0] memWriteData;
  logic             memMemWrite;
  logic [NBITS-1:0] memReadData;

  // Cache side: drives address, data and write level; receives read data.
  modport master (
    output memAddress,
    output memWriteData,
    output memMemWrite,
    input  memReadData
  );

  // Memory side: the mirror image of the master.
  modport slave (
    input  memAddress,
    input  memWriteData,
    input  memMemWrite,
    output memReadData
  );
endinterface
`default_nettype wire

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
//  Module   : main_memory
//  Purpose  : Word-addressed backing store behind the write-through cache.
//             Fixed-latency read pipeline (RD_LAT stages, write-first bypass),
//             one commit per memMemWrite pulse, sticky write-protocol flag.
//  Options  : define MAIN_MEMORY_STATS_EN to add rd_count / wr_count outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module main_memory #(
  parameter int NBITS  = 8,
  parameter int NA     = 6,
  parameter int RD_LAT = 2,
  parameter int WMAX   = 3
) (
  input  logic         clock,
  input  logic         reset,
  main_memory_if.slave bus,
  output logic         wr_err
`ifdef MAIN_MEMORY_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  localparam int DEPTH = 2 ** NA;

  // Hold counter must reach WMAX+1 so the overrun can be seen.
  localparam int              CW       = $clog2(WMAX + 2);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_WMAX = CW'(WMAX);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(WMAX + 1);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_HOLD = 1'b1;

  // Storage and read pipeline
  logic [NBITS-1:0] mem_q [DEPTH];
  logic [NBITS-1:0] rd_q  [RD_LAT];
  logic [NBITS-1:0] stage1_d;

  // Write FSM state
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NA-1:0]    addr_cap_q, addr_cap_d;
  logic [NBITS-1:0] data_cap_q, data_cap_d;
  logic             wr_err_q, wr_err_d;
  logic             wr_commit;

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_commit) begin
      mem_q[bus.memAddress] <= bus.memWriteData;
    end
  end

  // Stage 1 source: a commit always targets the address being read this
  // edge, so write-first simply means taking the incoming data.
  always_comb begin
    stage1_d = wr_commit ? bus.memWriteData : mem_q[bus.memAddress];
  end

  // Read pipeline: stage 1 samples the array, later stages shift forward.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      rd_q[0] <= stage1_d;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_q[i] <= rd_q[i-1];
      end
    end
  end

  assign bus.memReadData = rd_q[RD_LAT-1];

  // Write FSM state register plus the pulse-tracking registers it owns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= W_IDLE;
      cnt_q      <= '0;
      addr_cap_q <= '0;
      data_cap_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_cap_q <= addr_cap_d;
      data_cap_q <= data_cap_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Write FSM next state: a pulse is any unbroken run of memMemWrite high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:  if (bus.memMemWrite)  state_d = W_HOLD;
      W_HOLD:  if (!bus.memMemWrite) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs: commit on the first high cycle only, then police the
  // remainder of the pulse for stable address/data and excessive length.
  always_comb begin
    wr_commit  = 1'b0;
    cnt_d      = cnt_q;
    addr_cap_d = addr_cap_q;
    data_cap_d = data_cap_q;
    wr_err_d   = wr_err_q;
    case (state_q)
      W_IDLE: begin
        if (bus.memMemWrite) begin
          wr_commit  = 1'b1;
          addr_cap_d = bus.memAddress;
          data_cap_d = bus.memWriteData;
          cnt_d      = CNT_ONE;
        end
      end
      W_HOLD: begin
        if (bus.memMemWrite) begin
          if (cnt_q < CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if ((bus.memAddress != addr_cap_q) ||
              (bus.memWriteData != data_cap_q)) begin
            wr_err_d = 1'b1;
          end
          if (cnt_q >= CNT_WMAX) begin
            wr_err_d = 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign wr_err = wr_err_q;

`ifdef MAIN_MEMORY_STATS_EN
  logic [NA-1:0] addr_prev_q;
  logic [15:0]   rd_cnt_q;
  logic [15:0]   wr_cnt_q;

  // Saturating activity counters: address changes while not writing, and
  // write commits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_prev_q <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      addr_prev_q <= bus.memAddress;
      if (!bus.memMemWrite && (bus.memAddress != addr_prev_q) &&
          (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (wr_commit && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_memory
//  Purpose  : Directed self-checking bench for main_memory (RD_LAT=2, WMAX=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_main_memory;

  logic clock;
  logic reset;
  logic wr_err;
`ifdef MAIN_MEMORY_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int tests = 0;
  int fails = 0;

  main_memory_if #(.NBITS(8), .NA(6)) bus ();

  main_memory #(
    .NBITS (8),
    .NA    (6),
    .RD_LAT(2),
    .WMAX  (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .wr_err  (wr_err)
`ifdef MAIN_MEMORY_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One well-formed write pulse of n high cycles followed by one low cycle.
  task automatic wpulse(input logic [5:0] a, input logic [7:0] d, input int n);
    bus.memAddress   = a;
    bus.memWriteData = d;
    bus.memMemWrite  = 1'b1;
    repeat (n) tick();
    bus.memMemWrite  = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.memAddress   = '0;
    bus.memWriteData = '0;
    bus.memMemWrite  = 1'b0;
    #2;
    check("reset_rdata", 16'(bus.memReadData), 16'h00);
    check("reset_err",   16'(wr_err),          16'h0);
    tick();
    tick();
    reset = 1'b0;

    // Load two words, then a 3-cycle legal pulse.
    wpulse(6'h2A, 8'h5C, 1);
    wpulse(6'h11, 8'hA5, 3);
    check("pulse_err", 16'(wr_err), 16'h0);
    tick();
    check("rd_11", 16'(bus.memReadData), 16'hA5);
`ifdef MAIN_MEMORY_STATS_EN
    check("wr_count_2", wr_count, 16'd2);
`endif

    // Latency: address 2A presented before edge 0, data after edge 1.
    bus.memAddress = 6'h2A;
    tick();
    check("lat_edge0", 16'(bus.memReadData), 16'hA5);
    tick();
    check("lat_edge1", 16'(bus.memReadData), 16'h5C);

    // Write-first bypass with a simultaneous address change.
    wpulse(6'h07, 8'h00, 1);
    bus.memAddress = 6'h11;
    tick();
    tick();
    bus.memAddress   = 6'h07;
    bus.memWriteData = 8'h3C;
    bus.memMemWrite  = 1'b1;
    tick();
    check("byp_edgek", 16'(bus.memReadData), 16'hA5);
    bus.memMemWrite = 1'b0;
    tick();
    check("byp_edgek1", 16'(bus.memReadData), 16'h3C);

    // Data changes inside a pulse: first value kept, sticky error.
    bus.memAddress   = 6'h20;
    bus.memWriteData = 8'h01;
    bus.memMemWrite  = 1'b1;
    tick();
    check("chg_err_before", 16'(wr_err), 16'h0);
    bus.memWriteData = 8'h02;
    tick();
    check("chg_err_set", 16'(wr_err), 16'h1);
    bus.memMemWrite = 1'b0;
    tick();
    tick();
    check("chg_mem", 16'(bus.memReadData), 16'h01);
    tick();
    tick();
    check("chg_sticky", 16'(wr_err), 16'h1);

    // Reset clears the flag but not the array.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_err_clr", 16'(wr_err), 16'h0);
    check("rst_rd_clr", 16'(bus.memReadData), 16'h00);
    bus.memAddress = 6'h11;
    tick();
    tick();
    check("keep_11", 16'(bus.memReadData), 16'hA5);

    // Overlong pulse: error on the 4th high cycle.
    bus.memAddress   = 6'h30;
    bus.memWriteData = 8'h77;
    bus.memMemWrite  = 1'b1;
    tick();
    check("long_c1", 16'(wr_err), 16'h0);
    tick();
    check("long_c2", 16'(wr_err), 16'h0);
    tick();
    check("long_c3", 16'(wr_err), 16'h0);
    tick();
    check("long_c4", 16'(wr_err), 16'h1);
    tick();
    bus.memMemWrite = 1'b0;
    tick();
    tick();
    check("long_mem", 16'(bus.memReadData), 16'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("long_rst_err", 16'(wr_err), 16'h0);
    tick();
    tick();
    check("long_keep", 16'(bus.memReadData), 16'h77);

    // Asynchronous reset in the middle of a pulse.
    bus.memAddress   = 6'h3F;
    bus.memWriteData = 8'h99;
    bus.memMemWrite  = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_rd0", 16'(bus.memReadData), 16'h00);
    check("mid_rst_err", 16'(wr_err), 16'h0);
    bus.memWriteData = 8'h66;
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    check("mid_new_commit_err", 16'(wr_err), 16'h0);
    bus.memWriteData = 8'h67;
    tick();
    check("mid_hold_state", 16'(wr_err), 16'h1);
    bus.memMemWrite = 1'b0;
    tick();
    tick();
    check("mid_mem", 16'(bus.memReadData), 16'h66);
`ifdef MAIN_MEMORY_STATS_EN
    check("wr_count_1", wr_count, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
